// File: rtl/bkm_step_stim.sv
// bkm_step_stim: fetches packed vectors from a synchronous ROM, drives bkm_step and a LAT-aligned checker.
// Optional macro BKM_STIM_LOOP_EN: while start stays high, each finished pass restarts at rom_addr 0.
module bkm_step_stim #(
   parameter int WC    = 16,
   parameter int WD    = 64,
   parameter int LOG2N = 6,
   parameter int AW    = 10,
   parameter int LAT   = 1,
   localparam int VW   = 9 + LOG2N + 4*WC + 4*WD
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             srst,
   input  logic             start,
   input  logic             pause,
   input  logic [AW:0]      num_vec,
   output logic [AW-1:0]    rom_addr,
   input  logic [VW-1:0]    rom_data,
   output logic             dut_valid,
   output logic             dut_mode,
   output logic [1:0]       dut_format,
   output logic [LOG2N-1:0] dut_n,
   output logic [1:0]       dut_d_x_n,
   output logic [1:0]       dut_d_y_n,
   output logic [WC-1:0]    dut_u_n,
   output logic [WC-1:0]    dut_v_n,
   output logic [WD-1:0]    dut_X_n,
   output logic [WD-1:0]    dut_Y_n,
   output logic             chk_enable,
   output logic             chk_mode,
   output logic [1:0]       chk_format,
   output logic [LOG2N-1:0] chk_n,
   output logic [1:0]       chk_d_x_n,
   output logic [1:0]       chk_d_y_n,
   output logic [WC-1:0]    chk_u_n,
   output logic [WC-1:0]    chk_v_n,
   output logic [WD-1:0]    chk_X_n,
   output logic [WD-1:0]    chk_Y_n,
   output logic [WC-1:0]    chk_u_np1,
   output logic [WC-1:0]    chk_v_np1,
   output logic [WD-1:0]    chk_X_np1,
   output logic [WD-1:0]    chk_Y_np1,
   output logic             busy,
   output logic             done,
   output logic [AW:0]      vec_cnt
);

   // Field order matches the ROM word; the two top bits of the word are spare.
   typedef struct packed {
      logic             mode;
      logic [1:0]       format;
      logic [LOG2N-1:0] n;
      logic [1:0]       d_x_n;
      logic [1:0]       d_y_n;
      logic [WC-1:0]    u_n;
      logic [WC-1:0]    v_n;
      logic [WC-1:0]    u_np1;
      logic [WC-1:0]    v_np1;
      logic [WD-1:0]    X_n;
      logic [WD-1:0]    Y_n;
      logic [WD-1:0]    X_np1;
      logic [WD-1:0]    Y_np1;
   } vec_t;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t      state;
   logic        start_q;
   logic        issue_q;
   logic        pipe_busy;
   logic [AW:0] rem;
   vec_t        rom_vec;
   vec_t        dut_q;
   vec_t        chk_q;
   logic        unused_spare;
`ifdef BKM_STIM_LOOP_EN
   logic [AW:0] num_vec_q;
`endif

   assign rom_vec      = rom_data[VW-3:0];
   assign unused_spare = ^rom_data[VW-1:VW-2];

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state    <= S_IDLE;
         start_q  <= 1'b0;
         issue_q  <= 1'b0;
         rem      <= '0;
         rom_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         vec_cnt  <= '0;
`ifdef BKM_STIM_LOOP_EN
         num_vec_q <= '0;
`endif
      end else if (srst) begin
         // start_q keeps tracking start so a level held across srst is not taken as a new edge
         state    <= S_IDLE;
         start_q  <= start;
         issue_q  <= 1'b0;
         rem      <= '0;
         rom_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         vec_cnt  <= '0;
`ifdef BKM_STIM_LOOP_EN
         num_vec_q <= '0;
`endif
      end else begin
         start_q <= start;
         issue_q <= 1'b0;
         done    <= 1'b0;
         if (chk_enable && vec_cnt != '1)
            vec_cnt <= vec_cnt + 1'b1;
         case (state)
            S_IDLE: begin
               if (start && !start_q) begin
                  rem      <= num_vec;
                  rom_addr <= '0;
                  vec_cnt  <= '0;
                  busy     <= 1'b1;
`ifdef BKM_STIM_LOOP_EN
                  num_vec_q <= num_vec;
`endif
                  state    <= (num_vec == '0) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               if (!pause) begin
                  issue_q  <= 1'b1;
                  rom_addr <= rom_addr + 1'b1;
                  rem      <= rem - 1'b1;
                  if (rem == (AW+1)'(1)) begin
`ifdef BKM_STIM_LOOP_EN
                     if (start) begin
                        rom_addr <= '0;
                        rem      <= num_vec_q;
                     end else begin
                        state <= S_DRAIN;
                     end
`else
                     state <= S_DRAIN;
`endif
                  end
               end
            end
            S_DRAIN: begin
               // Finish once only the checker stage can still hold a vector.
               if (!pipe_busy) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         dut_valid <= 1'b0;
         dut_q     <= '0;
      end else if (srst) begin
         dut_valid <= 1'b0;
         dut_q     <= '0;
      end else begin
         dut_valid <= issue_q;
         if (issue_q)
            dut_q <= rom_vec;
      end
   end

   generate
      if (LAT == 0) begin : g_no_delay
         assign chk_q      = dut_q;
         assign chk_enable = dut_valid;
         assign pipe_busy  = issue_q;
      end else begin : g_delay
         vec_t           dly_q [LAT];
         logic [LAT-1:0] dly_v;

         // NOTE: the delay line is a register array, yet it is reset so that chk_* read 0 after any reset.
         always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
               dly_v <= '0;
               for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
            end else if (srst) begin
               dly_v <= '0;
               for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
            end else begin
               dly_v[0] <= dut_valid;
               dly_q[0] <= dut_q;
               for (int i = 1; i < LAT; i++) begin
                  dly_v[i] <= dly_v[i-1];
                  dly_q[i] <= dly_q[i-1];
               end
            end
         end

         assign chk_q      = dly_q[LAT-1];
         assign chk_enable = dly_v[LAT-1];
         if (LAT == 1) begin : g_one
            assign pipe_busy = issue_q | dut_valid;
         end else begin : g_many
            assign pipe_busy = issue_q | dut_valid | (|dly_v[LAT-2:0]);
         end
      end
   endgenerate

   assign dut_mode   = dut_q.mode;
   assign dut_format = dut_q.format;
   assign dut_n      = dut_q.n;
   assign dut_d_x_n  = dut_q.d_x_n;
   assign dut_d_y_n  = dut_q.d_y_n;
   assign dut_u_n    = dut_q.u_n;
   assign dut_v_n    = dut_q.v_n;
   assign dut_X_n    = dut_q.X_n;
   assign dut_Y_n    = dut_q.Y_n;

   assign chk_mode   = chk_q.mode;
   assign chk_format = chk_q.format;
   assign chk_n      = chk_q.n;
   assign chk_d_x_n  = chk_q.d_x_n;
   assign chk_d_y_n  = chk_q.d_y_n;
   assign chk_u_n    = chk_q.u_n;
   assign chk_v_n    = chk_q.v_n;
   assign chk_X_n    = chk_q.X_n;
   assign chk_Y_n    = chk_q.Y_n;
   assign chk_u_np1  = chk_q.u_np1;
   assign chk_v_np1  = chk_q.v_np1;
   assign chk_X_np1  = chk_q.X_np1;
   assign chk_Y_np1  = chk_q.Y_np1;

endmodule

// File: tb/tb_bkm_step_stim.sv
// Directed bench for bkm_step_stim: one LAT=1 and one LAT=3 instance, each fed by a bench ROM model.
module tb_bkm_step_stim;

   localparam int VW = 335;

   logic clk, arst, srst, pause;
   int   total, bad;

   logic          a_start, a_dut_valid, a_dut_mode, a_chk_enable, a_chk_mode, a_busy, a_done;
   logic [10:0]   a_num_vec, a_vec_cnt;
   logic [9:0]    a_rom_addr;
   logic [VW-1:0] a_rom_data;
   logic [1:0]    a_dut_format, a_dut_d_x_n, a_dut_d_y_n, a_chk_format, a_chk_d_x_n, a_chk_d_y_n;
   logic [5:0]    a_dut_n, a_chk_n;
   logic [15:0]   a_dut_u_n, a_dut_v_n, a_chk_u_n, a_chk_v_n, a_chk_u_np1, a_chk_v_np1;
   logic [63:0]   a_dut_X_n, a_dut_Y_n, a_chk_X_n, a_chk_Y_n, a_chk_X_np1, a_chk_Y_np1;

   logic          b_start, b_dut_valid, b_dut_mode, b_chk_enable, b_chk_mode, b_busy, b_done;
   logic [10:0]   b_num_vec, b_vec_cnt;
   logic [9:0]    b_rom_addr;
   logic [VW-1:0] b_rom_data;
   logic [1:0]    b_dut_format, b_dut_d_x_n, b_dut_d_y_n, b_chk_format, b_chk_d_x_n, b_chk_d_y_n;
   logic [5:0]    b_dut_n, b_chk_n;
   logic [15:0]   b_dut_u_n, b_dut_v_n, b_chk_u_n, b_chk_v_n, b_chk_u_np1, b_chk_v_np1;
   logic [63:0]   b_dut_X_n, b_dut_Y_n, b_chk_X_n, b_chk_Y_n, b_chk_X_np1, b_chk_Y_np1;

   bkm_step_stim #(.LAT(1)) u_a (
      .clk(clk), .arst(arst), .srst(srst), .start(a_start), .pause(pause), .num_vec(a_num_vec),
      .rom_addr(a_rom_addr), .rom_data(a_rom_data),
      .dut_valid(a_dut_valid), .dut_mode(a_dut_mode), .dut_format(a_dut_format), .dut_n(a_dut_n),
      .dut_d_x_n(a_dut_d_x_n), .dut_d_y_n(a_dut_d_y_n), .dut_u_n(a_dut_u_n), .dut_v_n(a_dut_v_n),
      .dut_X_n(a_dut_X_n), .dut_Y_n(a_dut_Y_n),
      .chk_enable(a_chk_enable), .chk_mode(a_chk_mode), .chk_format(a_chk_format), .chk_n(a_chk_n),
      .chk_d_x_n(a_chk_d_x_n), .chk_d_y_n(a_chk_d_y_n), .chk_u_n(a_chk_u_n), .chk_v_n(a_chk_v_n),
      .chk_X_n(a_chk_X_n), .chk_Y_n(a_chk_Y_n), .chk_u_np1(a_chk_u_np1), .chk_v_np1(a_chk_v_np1),
      .chk_X_np1(a_chk_X_np1), .chk_Y_np1(a_chk_Y_np1),
      .busy(a_busy), .done(a_done), .vec_cnt(a_vec_cnt)
   );

   bkm_step_stim #(.LAT(3)) u_b (
      .clk(clk), .arst(arst), .srst(srst), .start(b_start), .pause(pause), .num_vec(b_num_vec),
      .rom_addr(b_rom_addr), .rom_data(b_rom_data),
      .dut_valid(b_dut_valid), .dut_mode(b_dut_mode), .dut_format(b_dut_format), .dut_n(b_dut_n),
      .dut_d_x_n(b_dut_d_x_n), .dut_d_y_n(b_dut_d_y_n), .dut_u_n(b_dut_u_n), .dut_v_n(b_dut_v_n),
      .dut_X_n(b_dut_X_n), .dut_Y_n(b_dut_Y_n),
      .chk_enable(b_chk_enable), .chk_mode(b_chk_mode), .chk_format(b_chk_format), .chk_n(b_chk_n),
      .chk_d_x_n(b_chk_d_x_n), .chk_d_y_n(b_chk_d_y_n), .chk_u_n(b_chk_u_n), .chk_v_n(b_chk_v_n),
      .chk_X_n(b_chk_X_n), .chk_Y_n(b_chk_Y_n), .chk_u_np1(b_chk_u_np1), .chk_v_np1(b_chk_v_np1),
      .chk_X_np1(b_chk_X_np1), .chk_Y_np1(b_chk_Y_np1),
      .busy(b_busy), .done(b_done), .vec_cnt(b_vec_cnt)
   );

   // ROM[k]: n=k, X_n=k+1, X_np1=100+k, u_np1=200+k, mode=k[0]; spare bits set to show they are ignored.
   function automatic logic [VW-1:0] make_vec(input logic [9:0] k);
      logic [VW-1:0] w;
      w            = '0;
      w[334:333]   = 2'b11;
      w[332]       = k[0];
      w[329:324]   = k[5:0];
      w[287:272]   = 16'd200 + 16'(k);
      w[255:192]   = 64'(k) + 64'd1;
      w[127:64]    = 64'(k) + 64'd100;
      return w;
   endfunction

   always @(posedge clk) begin
      a_rom_data <= make_vec(a_rom_addr);
      b_rom_data <= make_vec(b_rom_addr);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic exp_a(input string s, input int addr, input int dv, input int xn, input int ce,
                        input int xnp1, input int bz, input int dn, input int vc);
      check({s, ".rom_addr"},  64'(a_rom_addr),   64'(addr));
      check({s, ".dut_valid"}, 64'(a_dut_valid),  64'(dv));
      check({s, ".dut_X_n"},   a_dut_X_n,         64'(xn));
      check({s, ".chk_en"},    64'(a_chk_enable), 64'(ce));
      check({s, ".chk_X_np1"}, a_chk_X_np1,       64'(xnp1));
      check({s, ".busy"},      64'(a_busy),       64'(bz));
      check({s, ".done"},      64'(a_done),       64'(dn));
      check({s, ".vec_cnt"},   64'(a_vec_cnt),    64'(vc));
   endtask

   task automatic exp_b(input string s, input int addr, input int dv, input int xn, input int ce,
                        input int xnp1, input int bz, input int dn, input int vc);
      check({s, ".rom_addr"},  64'(b_rom_addr),   64'(addr));
      check({s, ".dut_valid"}, 64'(b_dut_valid),  64'(dv));
      check({s, ".dut_X_n"},   b_dut_X_n,         64'(xn));
      check({s, ".chk_en"},    64'(b_chk_enable), 64'(ce));
      check({s, ".chk_X_np1"}, b_chk_X_np1,       64'(xnp1));
      check({s, ".busy"},      64'(b_busy),       64'(bz));
      check({s, ".done"},      64'(b_done),       64'(dn));
      check({s, ".vec_cnt"},   64'(b_vec_cnt),    64'(vc));
   endtask

   task automatic wait_done_a(input string s, input int max_cycles);
      int n;
      n = 0;
      while (a_done !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      check({s, ".done_seen"}, 64'(a_done), 64'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0; bad = 0;
      arst = 1'b1; srst = 1'b0; pause = 1'b0;
      a_start = 1'b0; a_num_vec = '0; b_start = 1'b0; b_num_vec = '0;
      repeat (2) tick();
      exp_a("rst", 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst.b_chk_en", 64'(b_chk_enable), 64'd0);
      arst = 1'b0;
      tick();

      // Run of 4, no pause.
      a_start = 1'b1; a_num_vec = 11'd4;
      tick(); exp_a("t1c1", 0, 0, 0, 0, 0, 1, 0, 0);
      a_start = 1'b0;
      tick(); exp_a("t1c2", 1, 0, 0, 0, 0, 1, 0, 0);
      tick(); exp_a("t1c3", 2, 1, 1, 0, 0, 1, 0, 0);
      check("t1c3.dut_n", 64'(a_dut_n), 64'd0);
      tick(); exp_a("t1c4", 3, 1, 2, 1, 100, 1, 0, 0);
      check("t1c4.chk_X_n", a_chk_X_n, 64'd1);
      check("t1c4.dut_mode", 64'(a_dut_mode), 64'd1);
      tick(); exp_a("t1c5", 4, 1, 3, 1, 101, 1, 0, 1);
      tick(); exp_a("t1c6", 4, 1, 4, 1, 102, 1, 0, 2);
      check("t1c6.dut_n", 64'(a_dut_n), 64'd3);
      tick(); exp_a("t1c7", 4, 0, 4, 1, 103, 1, 0, 3);
      check("t1c7.chk_u_np1", 64'(a_chk_u_np1), 64'd203);
      tick(); exp_a("t1c8", 4, 0, 4, 0, 103, 0, 1, 4);
      tick(); exp_a("t1c9", 4, 0, 4, 0, 103, 0, 0, 4);

      // Run of 3 with two paused cycles after the first issue.
      a_start = 1'b1; a_num_vec = 11'd3;
      tick(); exp_a("t2c1", 0, 0, 4, 0, 103, 1, 0, 0);
      a_start = 1'b0;
      tick(); exp_a("t2c2", 1, 0, 4, 0, 103, 1, 0, 0);
      pause = 1'b1;
      tick(); exp_a("t2c3", 1, 1, 1, 0, 103, 1, 0, 0);
      tick(); exp_a("t2c4", 1, 0, 1, 1, 100, 1, 0, 0);
      pause = 1'b0;
      tick(); exp_a("t2c5", 2, 0, 1, 0, 100, 1, 0, 1);
      tick(); exp_a("t2c6", 3, 1, 2, 0, 100, 1, 0, 1);
      tick(); exp_a("t2c7", 3, 1, 3, 1, 101, 1, 0, 1);
      tick(); exp_a("t2c8", 3, 0, 3, 1, 102, 1, 0, 2);
      tick(); exp_a("t2c9", 3, 0, 3, 0, 102, 0, 1, 3);

      // Empty run; then start held high must not relaunch.
      a_start = 1'b1; a_num_vec = 11'd0;
      tick(); exp_a("t3c1", 0, 0, 3, 0, 102, 1, 0, 0);
      tick(); exp_a("t3c2", 0, 0, 3, 0, 102, 0, 1, 0);
      repeat (3) tick();
      check("t3.held_busy", 64'(a_busy), 64'd0);
      check("t3.held_done", 64'(a_done), 64'd0);

      // srst while vector 2 of 5 is in flight.
      a_start = 1'b0;
      tick();
      a_start = 1'b1; a_num_vec = 11'd5;
      tick(); tick(); tick(); tick();
      exp_a("t4c4", 3, 1, 2, 1, 100, 1, 0, 0);
      srst = 1'b1;
      tick();
      exp_a("t4rst", 0, 0, 0, 0, 0, 0, 0, 0);
      check("t4rst.dut_n", 64'(a_dut_n), 64'd0);
      check("t4rst.chk_u_np1", 64'(a_chk_u_np1), 64'd0);
      srst = 1'b0;
      tick(); tick();
      check("t4.after_busy", 64'(a_busy), 64'd0);
      check("t4.after_done", 64'(a_done), 64'd0);
      a_start = 1'b0;
      tick();
      a_start = 1'b1; a_num_vec = 11'd1;
      tick(); exp_a("t4r1", 0, 0, 0, 0, 0, 1, 0, 0);
      a_start = 1'b0;
      tick(); exp_a("t4r2", 1, 0, 0, 0, 0, 1, 0, 0);
      tick(); exp_a("t4r3", 1, 1, 1, 0, 0, 1, 0, 0);
      tick(); exp_a("t4r4", 1, 0, 1, 1, 100, 1, 0, 0);
      tick(); exp_a("t4r5", 1, 0, 1, 0, 100, 0, 1, 1);

      // LAT=3 instance, run of 2.
      b_start = 1'b1; b_num_vec = 11'd2;
      tick(); exp_b("t5c1", 0, 0, 0, 0, 0, 1, 0, 0);
      b_start = 1'b0;
      tick(); exp_b("t5c2", 1, 0, 0, 0, 0, 1, 0, 0);
      tick(); exp_b("t5c3", 2, 1, 1, 0, 0, 1, 0, 0);
      tick(); exp_b("t5c4", 2, 1, 2, 0, 0, 1, 0, 0);
      tick(); exp_b("t5c5", 2, 0, 2, 0, 0, 1, 0, 0);
      tick(); exp_b("t5c6", 2, 0, 2, 1, 100, 1, 0, 0);
      check("t5c6.chk_X_n", b_chk_X_n, 64'd1);
      tick(); exp_b("t5c7", 2, 0, 2, 1, 101, 1, 0, 1);
      tick(); exp_b("t5c8", 2, 0, 2, 0, 101, 0, 1, 2);

`ifdef BKM_STIM_LOOP_EN
      // Looping: num_vec=2, start held for 7 issues.
      tick();
      a_start = 1'b1; a_num_vec = 11'd2;
      tick(); check("t6c1.rom_addr", 64'(a_rom_addr), 64'd0);
      tick(); check("t6c2.rom_addr", 64'(a_rom_addr), 64'd1);
      tick(); check("t6c3.rom_addr", 64'(a_rom_addr), 64'd0);
      check("t6c3.dut_X_n", a_dut_X_n, 64'd1);
      tick(); check("t6c4.rom_addr", 64'(a_rom_addr), 64'd1);
      check("t6c4.chk_X_np1", a_chk_X_np1, 64'd100);
      tick(); check("t6c5.rom_addr", 64'(a_rom_addr), 64'd0);
      check("t6c5.dut_X_n", a_dut_X_n, 64'd1);
      tick(); check("t6c6.rom_addr", 64'(a_rom_addr), 64'd1);
      tick(); check("t6c7.rom_addr", 64'(a_rom_addr), 64'd0);
      tick(); check("t6c8.rom_addr", 64'(a_rom_addr), 64'd1);
      a_start = 1'b0;
      wait_done_a("t6", 10);
      check("t6.vec_cnt", 64'(a_vec_cnt), 64'd8);
      check("t6.chk_X_np1", a_chk_X_np1, 64'd101);
`endif

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bkm_step_stim.md
Name: bkm_step_stim

Overview:
- Stimulus source for bkm_step verification, on the opposite side of the DUT from the step checker.
- Fetches packed test vectors from a synchronous vector ROM and drives the bkm_step inputs.
- Delays each vector's inputs and expected values by the DUT latency, so the checker receives aligned tb_* fields with a qualifying enable.
- Sequencing is controlled by an FSM with start/pause and a vector counter.

Parameters:
WC, 16, control-path (u/v) width
WD, 64, data-path (X/Y) width
LOG2N, 6, width of step index n
AW, 10, vector ROM address width
LAT, 1, DUT latency in cycles from dut_* inputs to res_* outputs (0..8)

Ports:
clk  in  1  clock
arst  in  1  async reset, active-high
srst  in  1  sync reset, active-high
start  in  1  level; rising edge in IDLE launches a run
pause  in  1  holds off new ROM reads while high
num_vec  in  AW+1  vectors per run, sampled on launch
rom_addr  out  AW  ROM read address
rom_data  in  VW  vector word, valid 1 cycle after rom_addr; VW=9+LOG2N+4*WC+4*WD
dut_valid  out  1  dut_* hold a live vector
dut_mode, dut_format, dut_n, dut_d_x_n, dut_d_y_n  out  1/2/LOG2N/2/2  DUT control inputs
dut_u_n, dut_v_n  out  WC  DUT inputs
dut_X_n, dut_Y_n  out  WD  DUT inputs
chk_enable  out  1  checker enable; dut_valid delayed by LAT
chk_mode ... chk_Y_n  out  as dut_*  dut_* fields delayed by LAT
chk_u_np1, chk_v_np1  out  WC  expected values, aligned with chk_enable
chk_X_np1, chk_Y_np1  out  WD  expected values, aligned with chk_enable
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse at end of run
vec_cnt  out  AW+1  vectors delivered to checker this run

Behaviour:
- Vector word packing, MSB to LSB: mode, format, n, d_x_n, d_y_n, u_n, v_n, u_np1, v_np1, X_n, Y_n, X_np1, Y_np1.
- Reset (arst or srst): all outputs 0, FSM in IDLE, delay line cleared. srst mid-run aborts the run; done is not pulsed.
- IDLE:
  - Rising edge of start: latch num_vec, clear vec_cnt, set rom_addr=0.
  - Go to RUN, or to DRAIN if num_vec=0.
  - start held high without a new edge does not relaunch.
- RUN:
  - Each cycle with pause=0: a read is issued at rom_addr (issue flag set), and rom_addr increments.
  - After num_vec issues, go to DRAIN.
  - pause=1: no issue and rom_addr holds. Vectors already in flight continue; bubbles propagate as dut_valid=0.
- Pipeline:
  - Issue at cycle t.
  - rom_data is registered into dut_* at the end of cycle t+1, so dut_* and dut_valid=1 are present in cycle t+2.
  - dut_* hold their last value when dut_valid=0.
  - chk_* equal dut_* delayed LAT cycles. The delay line always advances and is not affected by pause.
  - LAT=0: chk_* = dut_* combinationally.
- DRAIN: wait until the pipeline holds no valid vector (at most 2+LAT cycles), then pulse done for 1 cycle and return to IDLE.
- vec_cnt increments on every cycle with chk_enable=1 and saturates at 2^(AW+1)-1.
- num_vec > 2^AW: rom_addr wraps modulo 2^AW; vectors repeat.
- start edge while busy: ignored.

Optional Feature:
- Macro BKM_STIM_LOOP_EN.
- Defined: on reaching num_vec issues in RUN, if start is still high, rom_addr returns to 0 and RUN continues seamlessly with no bubble. vec_cnt keeps counting (saturating). Deasserting start finishes the current pass, then DRAIN and done as normal.
- Undefined: a single pass per launch; start level is ignored after launch.

Test Plan:
- num_vec=4, LAT=1, ROM[k]={n=k, X_n=k+1, X_np1=100+k}, no pause -> rom_addr 0..3 on consecutive cycles. dut_valid high 4 cycles starting 2 cycles after first issue. chk_X_np1 shows 100,101,102,103 one cycle after dut_X_n shows 1..4. done pulses once; vec_cnt=4.
- num_vec=3, pause high for 2 cycles after the first issue -> exactly 2 bubbles (dut_valid=0) between vectors 0 and 1. chk_* ordering intact; vec_cnt=3.
- num_vec=0 -> busy for the drain cycles only, no chk_enable, done pulse, vec_cnt=0.
- srst asserted while vector 2 of 5 is in flight -> next cycle all outputs 0, IDLE, no done. A new start edge restarts from rom_addr=0.
- LAT=3, num_vec=2 -> chk_enable trails dut_valid by exactly 3 cycles. done follows the last chk_enable by 1 cycle.
- BKM_STIM_LOOP_EN, num_vec=2, start held for 7 issues then dropped -> rom_addr sequence 0,1,0,1,0,1,0,1. Exactly 8 vectors are checked, then done.
